// File: rtl/cpu_sram_responder.sv
// cpu_sram_responder: shared word array behind the core's instruction and data
// SRAM ports. One-cycle registered reads, byte-lane data writes,
// 64-bit dual-word fetch, sticky illegal-access capture for debug.

// One byte lane of the shared array. It has one write port and three
// asynchronous read ports: the data word and the two fetch words. The
// registered outputs in the top sample these reads before the same edge
// commits a write, so a colliding read returns the old byte.
module cpu_sram_lane #(
  parameter int AW    = 12,
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    d_idx,
  input  logic [VEC_W-1:0] w_dat,
  input  logic [AW-1:0]    i0_idx,
  input  logic [AW-1:0]    i1_idx,
  output logic [VEC_W-1:0] d_dat,
  output logic [VEC_W-1:0] i0_dat,
  output logic [VEC_W-1:0] i1_dat
);
  logic [VEC_W-1:0] mem [2**AW];

  // Array contents are never reset. The write enable already carries the reset gate.
  always_ff @(posedge clk)
    if (we) mem[d_idx] <= w_dat;

  assign d_dat  = mem[d_idx];
  assign i0_dat = mem[i0_idx];
  assign i1_dat = mem[i1_idx];
endmodule

module cpu_sram_responder #(
  parameter int          AW        = 12,
  parameter logic [31:0] BASE      = 32'h1FC0_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_C000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [63:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        err_flag,
  output logic [31:0] err_addr
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef struct packed {
    logic                 en;
    logic [NUM_LANES-1:0] wen;
    logic [31:0]          addr;
  } sram_req_t;

  sram_req_t ireq, dreq;
  assign ireq = '{en: inst_sram_en, wen: inst_sram_wen, addr: inst_sram_addr};
  assign dreq = '{en: data_sram_en, wen: data_sram_wen, addr: data_sram_addr};

  // The instruction port has a write-data bus, but this port never writes the array.
  logic unused_inst_wdata;
  assign unused_inst_wdata = ^inst_sram_wdata;

  // Decode the addresses and check the range. Only the fetch base address is
  // range-checked. The second fetch word wraps inside the array.
  logic [AW-1:0] d_idx, i_idx0, i_idx1;
  logic          d_in_rng, i_in_rng, d_ill, i_ill, d_wr;

  assign d_idx    = dreq.addr[AW+1:2];
  assign i_idx0   = ireq.addr[AW+1:2];
  assign i_idx1   = i_idx0 + AW'(1);
  assign d_in_rng = (dreq.addr & ADDR_MASK) == (BASE & ADDR_MASK);
  assign i_in_rng = (ireq.addr & ADDR_MASK) == (BASE & ADDR_MASK);
  assign d_ill    = dreq.en && !d_in_rng;
  assign i_ill    = ireq.en && (!i_in_rng || (ireq.addr[1:0] != 2'b00) || (ireq.wen != '0));
  // Block writes while reset is low, so an edge taken during reset cannot commit a write.
  assign d_wr     = dreq.en && d_in_rng && rst;

  logic [NUM_LANES-1:0][VEC_W-1:0] w_dat, d_word, i0_word, i1_word;
  logic [NUM_LANES-1:0]            lane_we;
  assign w_dat = data_sram_wdata;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_we[g] = d_wr && dreq.wen[g];
    cpu_sram_lane #(.AW(AW), .VEC_W(VEC_W)) u_lane (
      .clk    (clk),
      .we     (lane_we[g]),
      .d_idx  (d_idx),
      .w_dat  (w_dat[g]),
      .i0_idx (i_idx0),
      .i1_idx (i_idx1),
      .d_dat  (d_word[g]),
      .i0_dat (i0_word[g]),
      .i1_dat (i1_word[g])
    );
  end

  // Read-data registers load only when their port is enabled. Illegal
  // accesses return zero. A write returns the word as it was before the write.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      inst_sram_rdata <= '0;
      data_sram_rdata <= '0;
    end else begin
      if (dreq.en) data_sram_rdata <= d_ill ? 32'h0 : d_word;
      if (ireq.en) inst_sram_rdata <= i_ill ? 64'h0 : {i1_word, i0_word};
    end

  // The error flag is sticky. err_addr captures only the first offending
  // address. If both ports are illegal in the same cycle, the data port wins.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (d_ill || i_ill) begin
      err_flag <= 1'b1;
      if (!err_flag) err_addr <= d_ill ? dreq.addr : ireq.addr;
    end
endmodule

// File: tb/tb_cpu_sram_responder.sv
// Directed bench for cpu_sram_responder: reset, byte lanes, dual fetch/wrap,
// collision, illegal accesses, hold behaviour.
module tb_cpu_sram_responder;
  logic        clk, rst;
  logic        inst_sram_en, data_sram_en;
  logic [3:0]  inst_sram_wen, data_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata, data_sram_addr, data_sram_wdata;
  logic [63:0] inst_sram_rdata;
  logic [31:0] data_sram_rdata;
  logic        err_flag;
  logic [31:0] err_addr;

  int n_chk = 0;
  int n_err = 0;

  cpu_sram_responder dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .err_flag(err_flag), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_wr(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd);
    data_sram_en = 1'b1; data_sram_wen = wen; data_sram_addr = a; data_sram_wdata = wd;
  endtask

  task automatic d_rd(input logic [31:0] a);
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = a;
  endtask

  task automatic i_fetch(input logic [31:0] a, input logic [3:0] wen);
    inst_sram_en = 1'b1; inst_sram_wen = wen; inst_sram_addr = a;
  endtask

  task automatic idle();
    data_sram_en = 1'b0; data_sram_wen = 4'h0;
    inst_sram_en = 1'b0; inst_sram_wen = 4'h0;
  endtask

  initial begin
    // Test 1: hold reset while both ports request access.
    rst = 1'b0;
    inst_sram_wdata = 32'hFFFF_FFFF;
    d_wr(32'h1FC0_0000, 4'hF, 32'hFFFF_FFFF);
    i_fetch(32'h1FC0_0000, 4'h0);
    repeat (3) tick();
    chk("rst_inst", inst_sram_rdata, 64'h0);
    chk("rst_data", {32'h0, data_sram_rdata}, 64'h0);
    chk("rst_eflag", {63'h0, err_flag}, 64'h0);
    chk("rst_eaddr", {32'h0, err_addr}, 64'h0);
    idle();
    #2 rst = 1'b1;

    // Preload mem[0] and read it back.
    d_wr(32'h1FC0_0000, 4'hF, 32'h1234_5678); tick();
    d_rd(32'h1FC0_0000); tick();
    chk("preload_rd", {32'h0, data_sram_rdata}, 64'h1234_5678);
    i_fetch(32'h1FC0_0000, 4'h0); data_sram_en = 1'b0; tick();
    chk("preload_fetch_lo", {32'h0, inst_sram_rdata[31:0]}, 64'h1234_5678);

    // Assert reset in the middle of traffic. The outputs clear at once and the pending write is lost.
    d_wr(32'h1FC0_0000, 4'hF, 32'hFFFF_FFFF);
    i_fetch(32'h1FC0_0000, 4'h0);
    rst = 1'b0;
    #1;
    chk("midrst_async_data", {32'h0, data_sram_rdata}, 64'h0);
    chk("midrst_async_inst", inst_sram_rdata, 64'h0);
    tick();
    chk("midrst_data", {32'h0, data_sram_rdata}, 64'h0);
    idle();
    rst = 1'b1;
    d_rd(32'h1FC0_0000); tick();
    chk("midrst_nowrite", {32'h0, data_sram_rdata}, 64'h1234_5678);

    // Test 2: byte lanes, with read-first data returned on the write cycle.
    d_wr(32'h1FC0_0010, 4'hF, 32'hAABB_CCDD); tick();
    d_wr(32'h1FC0_0010, 4'b0101, 32'h1122_3344); tick();
    chk("lane_wr_old", {32'h0, data_sram_rdata}, 64'hAABB_CCDD);
    d_rd(32'h1FC0_0010); tick();
    chk("lane_merge", {32'h0, data_sram_rdata}, 64'hAA22_CC44);

    // Test 3: dual-word fetch and wrap at the top of the array.
    d_wr(32'h1FC0_0014, 4'hF, 32'h1); tick();
    d_wr(32'h1FC0_0018, 4'hF, 32'h2); tick();
    d_wr(32'h1FC0_3FFC, 4'hF, 32'hCAFE_F00D); tick();
    idle(); i_fetch(32'h1FC0_0014, 4'h0); tick();
    chk("fetch_dual", inst_sram_rdata, 64'h0000_0002_0000_0001);
    i_fetch(32'h1FC0_3FFC, 4'h0); tick();
    chk("fetch_wrap", inst_sram_rdata, 64'h1234_5678_CAFE_F00D);
    chk("fetch_wrap_noerr", {63'h0, err_flag}, 64'h0);

    // Test 4: a data write and a fetch of the same word in one cycle.
    idle();
    d_wr(32'h1FC0_0020, 4'hF, 32'h5566_7788); tick();
    d_wr(32'h1FC0_0024, 4'hF, 32'h0000_0099); tick();
    d_wr(32'h1FC0_0020, 4'hF, 32'hDEAD_BEEF);
    i_fetch(32'h1FC0_0020, 4'h0); tick();
    chk("coll_old", inst_sram_rdata, 64'h0000_0099_5566_7788);
    chk("coll_data_old", {32'h0, data_sram_rdata}, 64'h5566_7788);
    data_sram_en = 1'b0; tick();
    chk("coll_new", inst_sram_rdata, 64'h0000_0099_DEAD_BEEF);

    // Test 6: hold. With en=0, both read registers keep their values.
    idle();
    for (int k = 0; k < 10; k++) begin
      data_sram_addr = 32'h1FC0_0000 + 32'(k * 4);
      inst_sram_addr = 32'h1FC0_0010 + 32'(k * 4);
      data_sram_wen  = 4'(k);
      tick();
      chk("hold_inst", inst_sram_rdata, 64'h0000_0099_DEAD_BEEF);
      chk("hold_data", {32'h0, data_sram_rdata}, 64'h5566_7788);
    end

    // Test 5: illegal accesses.
    idle();
    d_wr(32'h1FC0_0040, 4'hF, 32'h0BAD_C0DE); tick();
    d_wr(32'h0000_0040, 4'hF, 32'h7777_7777); tick();
    chk("oor_wr_rdata", {32'h0, data_sram_rdata}, 64'h0);
    chk("oor_eflag", {63'h0, err_flag}, 64'h1);
    chk("oor_eaddr", {32'h0, err_addr}, 64'h0000_0040);
    d_rd(32'h1FC0_0040); tick();
    chk("oor_dropped", {32'h0, data_sram_rdata}, 64'h0BAD_C0DE);
    idle(); i_fetch(32'h1FC0_0014, 4'h0); tick();
    chk("pre_misalign", inst_sram_rdata, 64'h0000_0002_0000_0001);
    i_fetch(32'h1FC0_0002, 4'h0); tick();
    chk("misalign_zero", inst_sram_rdata, 64'h0);
    chk("misalign_eaddr", {32'h0, err_addr}, 64'h0000_0040);
    i_fetch(32'h1FC0_0014, 4'h0); tick();
    i_fetch(32'h1FC0_0014, 4'hF); tick();
    chk("iwen_zero", inst_sram_rdata, 64'h0);
    i_fetch(32'h1FC0_0014, 4'h0); tick();
    chk("iwen_nowrite", inst_sram_rdata, 64'h0000_0002_0000_0001);

    // After reset, both ports go illegal in one cycle. The data address is captured.
    idle();
    rst = 1'b0; tick(); rst = 1'b1; tick();
    chk("rst_clr_eflag", {63'h0, err_flag}, 64'h0);
    d_wr(32'h0000_0080, 4'hF, 32'h1);
    i_fetch(32'h2000_0000, 4'h0); tick();
    chk("both_eaddr", {32'h0, err_addr}, 64'h0000_0080);
    chk("both_inst_zero", inst_sram_rdata, 64'h0);
    idle(); i_fetch(32'h3000_0000, 4'h0); tick();
    chk("first_only", {32'h0, err_addr}, 64'h0000_0080);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
